// File: rtl/bank_cmd_arbiter_if.sv
// Bank command bus bundle: per-bank requests in, stall and the
// registered DRAM command out.
interface bank_cmd_arbiter_if #(
  parameter int NUM_BANKS = 8,
  parameter int ADDR_BITS = 14
);
  logic [NUM_BANKS-1:0]           req;
  logic [2*NUM_BANKS-1:0]         req_cmd;
  logic [ADDR_BITS*NUM_BANKS-1:0] req_addr;
  logic [NUM_BANKS-1:0]           stall;
  logic                           cmd_valid;
  logic [1:0]                     cmd;
  logic [2:0]                     cmd_bank;
  logic [ADDR_BITS-1:0]           cmd_addr;

  modport master (
    output req, req_cmd, req_addr,
    input  stall, cmd_valid, cmd, cmd_bank, cmd_addr
  );

  modport slave (
    input  req, req_cmd, req_addr,
    output stall, cmd_valid, cmd, cmd_bank, cmd_addr
  );
endinterface

// File: rtl/bank_cmd_arbiter.sv
// Round-robin DRAM command bus arbiter with per-bank and global
// timing counters (tRCD/tRP/tRAS/tRRD/tCCD/tWTR).
module bank_cmd_arbiter #(
  parameter int NUM_BANKS = 8,
  parameter int ADDR_BITS = 14,
  parameter int T_RCD     = 4,
  parameter int T_RP      = 4,
  parameter int T_RAS     = 10,
  parameter int T_RRD     = 2,
  parameter int T_CCD     = 2,
  parameter int T_WTR     = 3
) (
  input logic               clk,
  input logic               rst_n,
  input logic               init_done,
  bank_cmd_arbiter_if.slave bus
);

  localparam int CW = 8;
  localparam logic [1:0] C_ACT = 2'b00;
  localparam logic [1:0] C_RD  = 2'b01;
  localparam logic [1:0] C_WR  = 2'b10;
  localparam logic [1:0] C_PRE = 2'b11;

  typedef enum logic {
    WAIT_INIT,
    RUN
  } state_t;

  state_t                 r_state;
  logic [CW-1:0]          r_rcd [NUM_BANKS];
  logic [CW-1:0]          r_rp  [NUM_BANKS];
  logic [CW-1:0]          r_ras [NUM_BANKS];
  logic [CW-1:0]          r_rrd;
  logic [CW-1:0]          r_ccd;
  logic [CW-1:0]          r_wtr;
  logic [2:0]             r_last;
  logic                   r_cmd_valid;
  logic [1:0]             r_cmd;
  logic [2:0]             r_bank;
  logic [ADDR_BITS-1:0]   r_addr;

  logic [NUM_BANKS-1:0]   w_elig;
  logic                   w_gnt;
  logic [2:0]             w_gidx;
  logic [2:0]             w_i;
  logic [1:0]             w_gcmd;
  logic [ADDR_BITS-1:0]   w_gaddr;

  function automatic logic [CW-1:0] dec(input logic [CW-1:0] v);
    return (v == '0) ? v : v - CW'(1);
  endfunction

  always_comb begin
    w_elig = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      unique case (bus.req_cmd[2*i +: 2])
        C_ACT: w_elig[i] = (r_rp[i] == '0) && (r_rrd == '0);
        C_RD:  w_elig[i] = (r_rcd[i] == '0) && (r_ccd == '0)
                           && (r_wtr == '0);
        C_WR:  w_elig[i] = (r_rcd[i] == '0) && (r_ccd == '0);
        C_PRE: w_elig[i] = (r_ras[i] == '0);
      endcase
      w_elig[i] = w_elig[i] & bus.req[i];
    end
  end

  // First eligible bank scanning upward from the one after last_grant.
  always_comb begin
    w_gnt   = 1'b0;
    w_gidx  = '0;
    w_gcmd  = '0;
    w_gaddr = '0;
    w_i     = '0;
    for (int k = 0; k < NUM_BANKS; k++) begin
      w_i = 3'((int'(r_last) + 1 + k) % NUM_BANKS);
      if (!w_gnt && r_state == RUN && w_elig[w_i]) begin
        w_gnt   = 1'b1;
        w_gidx  = w_i;
        w_gcmd  = bus.req_cmd[2*w_i +: 2];
        w_gaddr = bus.req_addr[ADDR_BITS*w_i +: ADDR_BITS];
      end
    end
  end

  assign bus.stall = w_gnt ? ~(NUM_BANKS'(1) << w_gidx) : '1;

  assign bus.cmd_valid = r_cmd_valid;
  assign bus.cmd       = r_cmd;
  assign bus.cmd_bank  = r_bank;
  assign bus.cmd_addr  = r_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= WAIT_INIT;
      r_rrd       <= '0;
      r_ccd       <= '0;
      r_wtr       <= '0;
      r_last      <= 3'(NUM_BANKS - 1);
      r_cmd_valid <= 1'b0;
      r_cmd       <= '0;
      r_bank      <= '0;
      r_addr      <= '0;
      for (int i = 0; i < NUM_BANKS; i++) begin
        r_rcd[i] <= '0;
        r_rp[i]  <= '0;
        r_ras[i] <= '0;
      end
    end else begin
      unique case (r_state)
        WAIT_INIT: if (init_done) r_state <= RUN;
        RUN:       r_state <= RUN;
      endcase
      for (int i = 0; i < NUM_BANKS; i++) begin
        r_rcd[i] <= dec(r_rcd[i]);
        r_rp[i]  <= dec(r_rp[i]);
        r_ras[i] <= dec(r_ras[i]);
      end
      r_rrd       <= dec(r_rrd);
      r_ccd       <= dec(r_ccd);
      r_wtr       <= dec(r_wtr);
      r_cmd_valid <= w_gnt;
      // Loads below override the decrements above for the same cycle.
      if (w_gnt) begin
        r_cmd  <= w_gcmd;
        r_bank <= w_gidx;
        r_addr <= w_gaddr;
        r_last <= w_gidx;
        unique case (w_gcmd)
          C_ACT: begin
            r_rcd[w_gidx] <= CW'(T_RCD - 1);
            r_ras[w_gidx] <= CW'(T_RAS - 1);
            r_rrd         <= CW'(T_RRD - 1);
          end
          C_RD: r_ccd <= CW'(T_CCD - 1);
          C_WR: begin
            r_ccd <= CW'(T_CCD - 1);
            r_wtr <= CW'(T_WTR - 1);
          end
          C_PRE: r_rp[w_gidx] <= CW'(T_RP - 1);
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bank_cmd_arbiter.sv
// Bench for bank_cmd_arbiter: timestamp-based reference model,
// scoreboard queue, directed timing scenarios and random traffic.
module tb_bank_cmd_arbiter;

  localparam int N     = 8;
  localparam int AB    = 14;
  localparam int T_RCD = 4;
  localparam int T_RP  = 4;
  localparam int T_RAS = 10;
  localparam int T_RRD = 2;
  localparam int T_CCD = 2;
  localparam int T_WTR = 3;
  localparam int LONG_AGO = -1000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic init_done = 1'b0;

  bank_cmd_arbiter_if #(.NUM_BANKS(N), .ADDR_BITS(AB)) bus ();

  bank_cmd_arbiter #(
    .NUM_BANKS(N), .ADDR_BITS(AB),
    .T_RCD(T_RCD), .T_RP(T_RP), .T_RAS(T_RAS),
    .T_RRD(T_RRD), .T_CCD(T_CCD), .T_WTR(T_WTR)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .init_done(init_done),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          v;
    logic [1:0]  c;
    logic [2:0]  b;
    logic [AB-1:0] a;
  } exp_t;

  exp_t sbq[$];
  int n_cmp = 0;
  int n_err = 0;

  // Reference model: cycle stamps of the last command of each kind.
  bit tracking = 1'b0;
  bit m_run;
  int m_cyc;
  int m_last;
  int t_act[N];
  int t_pre[N];
  int t_act_g;
  int t_rw_g;
  int t_wr_g;
  logic [1:0]    l_c;
  logic [2:0]    l_b;
  logic [AB-1:0] l_a;

  task automatic model_reset();
    m_run = 1'b0;
    m_cyc = 0;
    m_last = N - 1;
    for (int i = 0; i < N; i++) begin
      t_act[i] = LONG_AGO;
      t_pre[i] = LONG_AGO;
    end
    t_act_g = LONG_AGO;
    t_rw_g = LONG_AGO;
    t_wr_g = LONG_AGO;
    sbq.delete();
    l_c = '0;
    l_b = '0;
    l_a = '0;
  endtask

  function automatic bit legal(int b, logic [1:0] c);
    case (c)
      2'b00: return (m_cyc - t_pre[b] >= T_RP)
                 && (m_cyc - t_act_g >= T_RRD);
      2'b01: return (m_cyc - t_act[b] >= T_RCD)
                 && (m_cyc - t_rw_g >= T_CCD)
                 && (m_cyc - t_wr_g >= T_WTR);
      2'b10: return (m_cyc - t_act[b] >= T_RCD)
                 && (m_cyc - t_rw_g >= T_CCD);
      default: return (m_cyc - t_act[b] >= T_RAS);
    endcase
  endfunction

  always @(negedge clk) begin : model
    int g;
    int b;
    logic [1:0] c;
    logic [N-1:0] xs;
    exp_t e;
    if (tracking) begin
      g = -1;
      if (m_run) begin
        for (int k = 0; k < N; k++) begin
          b = (m_last + 1 + k) % N;
          c = bus.req_cmd[2*b +: 2];
          if (g < 0 && bus.req[b] && legal(b, c)) g = b;
        end
      end
      xs = '1;
      e.v = 1'b0;
      e.c = '0;
      e.b = '0;
      e.a = '0;
      if (g >= 0) begin
        xs[g] = 1'b0;
        e.v = 1'b1;
        e.c = bus.req_cmd[2*g +: 2];
        e.b = 3'(g);
        e.a = bus.req_addr[AB*g +: AB];
      end
      n_cmp++;
      if (bus.stall !== xs) begin
        n_err++;
        $display("FAIL stall cyc%0d: got %b want %b", m_cyc, bus.stall, xs);
      end
      sbq.push_back(e);
      if (g >= 0) begin
        m_last = g;
        case (e.c)
          2'b00: begin t_act[g] = m_cyc; t_act_g = m_cyc; end
          2'b01: t_rw_g = m_cyc;
          2'b10: begin t_rw_g = m_cyc; t_wr_g = m_cyc; end
          default: t_pre[g] = m_cyc;
        endcase
      end
      if (!m_run && init_done) m_run = 1'b1;
      m_cyc++;
    end
  end

  always begin : monitor
    exp_t e;
    bit bad;
    @(posedge clk);
    #2;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      bad = (bus.cmd_valid !== e.v);
      if (e.v) begin
        if ({bus.cmd, bus.cmd_bank, bus.cmd_addr} !== {e.c, e.b, e.a})
          bad = 1'b1;
        l_c = e.c;
        l_b = e.b;
        l_a = e.a;
      end else if ({bus.cmd, bus.cmd_bank, bus.cmd_addr} !== {l_c, l_b, l_a}) begin
        bad = 1'b1;
      end
      n_cmp++;
      if (bad) begin
        n_err++;
        $display("FAIL cmd_out: got v%0b c%0d b%0d a%h want v%0b c%0d b%0d a%h",
                 bus.cmd_valid, bus.cmd, bus.cmd_bank, bus.cmd_addr,
                 e.v, e.v ? e.c : l_c, e.v ? e.b : l_b, e.v ? e.a : l_a);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    bus.req = '0;
    repeat (n) tick();
  endtask

  task automatic set_bank(int b, logic [1:0] c);
    bus.req[b] = 1'b1;
    bus.req_cmd[2*b +: 2] = c;
    bus.req_addr[AB*b +: AB] = AB'(14'h0100 + b * 14'h0011 + $urandom_range(0, 15));
  endtask

  task automatic check(string nm, logic [31:0] got, logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  // Cycles from now until bank b is granted (stall[b] low).
  task automatic wait_grant(int b, int exp_n, string nm);
    int n;
    bit hit;
    n = 0;
    hit = 1'b0;
    while (!hit && n < 20) begin
      @(negedge clk);
      if (!bus.stall[b]) hit = 1'b1;
      tick();
      if (!hit) n++;
    end
    n_cmp++;
    if (!hit || n != exp_n) begin
      n_err++;
      $display("FAIL %s: bank %0d granted after %0d cycles (hit=%0b), want %0d",
               nm, b, n, hit, exp_n);
    end
  endtask

  initial begin
    bus.req = '0;
    bus.req_cmd = '0;
    bus.req_addr = '0;
    model_reset();
    #3;
    check("rst_stall", 32'(bus.stall), 32'hFF);
    check("rst_valid", 32'(bus.cmd_valid), 0);
    check("rst_cmd", {bus.cmd, bus.cmd_bank, bus.cmd_addr}, 0);
    tick();
    rst_n = 1'b1;
    tracking = 1'b1;

    // Init gating
    for (int i = 0; i < N; i++) set_bank(i, 2'b00);
    repeat (4) tick();
    init_done = 1'b1;
    wait_grant(0, 1, "init_first");
    idle(12);

    // Round robin over PRE requesters
    set_bank(1, 2'b11);
    set_bank(3, 2'b11);
    set_bank(5, 2'b11);
    wait_grant(1, 0, "rr1a");
    wait_grant(3, 0, "rr3a");
    wait_grant(5, 0, "rr5a");
    wait_grant(1, 0, "rr1b");
    wait_grant(3, 0, "rr3b");
    wait_grant(5, 0, "rr5b");
    idle(12);

    // tRCD
    set_bank(2, 2'b00);
    wait_grant(2, 0, "act2");
    set_bank(2, 2'b01);
    wait_grant(2, 3, "trcd");
    idle(12);

    // tRRD and tRP
    set_bank(0, 2'b00);
    set_bank(1, 2'b00);
    wait_grant(0, 0, "act0");
    bus.req[0] = 1'b0;
    wait_grant(1, 1, "trrd");
    bus.req = '0;
    set_bank(4, 2'b11);
    wait_grant(4, 0, "pre4");
    set_bank(4, 2'b00);
    wait_grant(4, 3, "trp");
    idle(12);

    // tWTR with an eligible PRE bypassing the blocked RD
    set_bank(0, 2'b10);
    wait_grant(0, 0, "wr0");
    bus.req = '0;
    set_bank(1, 2'b01);
    set_bank(2, 2'b11);
    wait_grant(2, 0, "bypass");
    bus.req[2] = 1'b0;
    wait_grant(1, 1, "twtr");
    idle(4);

    // Random traffic
    for (int n = 0; n < 300; n++) begin
      bus.req = N'($urandom);
      bus.req_cmd = (2*N)'($urandom);
      for (int i = 0; i < N; i++)
        bus.req_addr[AB*i +: AB] = AB'($urandom);
      tick();
    end
    idle(12);

    // Reset during a grant cycle
    for (int i = 0; i < N; i++) set_bank(i, 2'b11);
    tick();
    tracking = 1'b0;
    @(negedge clk);
    check("pre_rst_valid", 32'(bus.cmd_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid", 32'(bus.cmd_valid), 0);
    check("rst_mid_stall", 32'(bus.stall), 32'hFF);
    check("rst_mid_cmd", {bus.cmd, bus.cmd_bank, bus.cmd_addr}, 0);
    init_done = 1'b0;
    tick();
    check("rst_hold_valid", 32'(bus.cmd_valid), 0);
    model_reset();
    rst_n = 1'b1;
    tracking = 1'b1;
    repeat (4) tick();
    init_done = 1'b1;
    wait_grant(0, 1, "reinit_first");
    repeat (4) tick();
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bank_cmd_arbiter.md
BANK_CMD_ARBITER -- requirements
Module: bank_cmd_arbiter

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  NUM_BANKS  8   number of bank FSMs sharing the command bus
  ADDR_BITS  14  row/col address width
  T_RCD      4   ACT to RD/WR, same bank, cycles
  T_RP       4   PRE to ACT, same bank, cycles
  T_RAS      10  ACT to PRE, same bank, cycles
  T_RRD      2   ACT to ACT, any banks, cycles
  T_CCD      2   RD/WR to RD/WR, any banks, cycles
  T_WTR      3   WR to RD, any banks, cycles
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  clk        in   1                       single clock, rising edge
  rst_n      in   1                       asynchronous active-low reset
  init_done  in   1                       1 = DRAM init complete
  req        in   NUM_BANKS               bank i holds a command in a CHECK state
  req_cmd    in   2*NUM_BANKS             per bank: 00 ACT, 01 RD, 10 WR, 11 PRE
  req_addr   in   ADDR_BITS*NUM_BANKS     per bank row or col address
  stall      out  NUM_BANKS               1 = bank i not granted this cycle
  cmd_valid  out  1                       command on bus this cycle
  cmd        out  2                       encoding as req_cmd
  cmd_bank   out  3                       target bank
  cmd_addr   out  ADDR_BITS               target address

Function
REQ-003 A two-state FSM SHALL operate: WAIT_INIT (all stall=1, no grants), moving to RUN on the first cycle init_done=1; RUN is held until reset.
REQ-004 In RUN, at most one bank SHALL be granted per cycle, chosen among eligible requesters.
REQ-005 Bank i is eligible when req[i]=1 and its command meets all timing rules REQ-008..REQ-010 this cycle.
REQ-006 Selection SHALL be round-robin: search starts at (last_grant+1) mod NUM_BANKS; last_grant resets to NUM_BANKS-1, so bank 0 has first priority.
REQ-007 stall SHALL be combinational: stall[i]=0 only for the granted bank; all other bits 1, including non-requesting banks.
REQ-008 Per-bank counters SHALL be kept: rcd[i], rp[i], ras[i]. ACT grant loads rcd=T_RCD-1 and ras=T_RAS-1. PRE grant loads rp=T_RP-1.
REQ-009 Global counters SHALL be kept: rrd (loaded T_RRD-1 on any ACT), ccd (T_CCD-1 on any RD/WR), wtr (T_WTR-1 on any WR).
REQ-010 Per-command legality:
  - ACT needs rp[i]=0 and rrd=0.
  - RD needs rcd[i]=0, ccd=0 and wtr=0.
  - WR needs rcd[i]=0 and ccd=0.
  - PRE needs ras[i]=0.
REQ-011 Every counter SHALL decrement by 1 per cycle and saturate at 0. A load in the same cycle overrides the decrement.
REQ-012 Timing parameters SHALL be >=1. A value of 1 permits the same command class on the next cycle.
REQ-013 The granted command SHALL appear on cmd/cmd_bank/cmd_addr with cmd_valid=1 exactly one cycle after grant (registered outputs).
REQ-014 With no grant, cmd_valid SHALL be 0 next cycle and cmd/cmd_bank/cmd_addr SHALL hold their previous values.
REQ-015 A requester whose req drops without a grant SHALL be dropped silently; no state is kept for it.
REQ-016 If eligible requests exist, a grant SHALL occur every cycle (work-conserving); an ineligible requester SHALL NOT block an eligible one.

Reset
REQ-017 While rst_n=0, outputs SHALL be asynchronously forced to:
  - cmd_valid=0, cmd=0, cmd_bank=0, cmd_addr=0, stall=all ones.
  - FSM=WAIT_INIT, all counters=0, last_grant=NUM_BANKS-1.
REQ-018 Reset asserted mid-operation SHALL abort any pending registered command; no command issues on the cycle after deassertion.

Verification
REQ-019 The bench SHALL cover these scenarios:
  - Init gating: init_done=0, req=8'hFF -> stall=8'hFF and cmd_valid=0 throughout. Raise init_done -> bank 0 granted on the next cycle.
  - Round-robin: banks 1,3,5 request PRE continuously, counters clear -> grant order 1,3,5,1,3,5. cmd_valid=1 every cycle from the second cycle on.
  - tRCD: ACT bank 2 granted at cycle t, RD bank 2 requested from t+1 -> RD granted at t+4, cmd_valid for it at t+5.
  - tRRD and tRP:
      - ACT bank 0 at t; ACT bank 1 requested -> granted at t+2.
      - PRE bank 4 at t; ACT bank 4 requested -> granted at t+4.
  - tWTR with eligible bypass:
      - WR bank 0 at t; RD bank 1 (rcd=0) at t+1 -> stalled until t+3.
      - PRE bank 2 requested at t+1 -> granted at t+1.
  - Reset mid-operation: rst_n pulled low during a grant cycle -> cmd_valid=0 immediately. After release: FSM in WAIT_INIT, stall=all ones.
